// File: rtl/dsram_arbiter.sv
// Data SRAM port arbiter: pipeline (priority) vs one auxiliary requester, with read-owner tracking.
// Optional starvation guard for the aux side is enabled by defining DSRAM_STARVE_GUARD_EN.
module dsram_arbiter #(
  parameter int ADDR_WD      = 32,
  parameter int DATA_WD      = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   pl_en,
  input  logic [DATA_WD/8-1:0]   pl_we,
  input  logic [ADDR_WD-1:0]     pl_addr,
  input  logic [DATA_WD-1:0]     pl_wdata,
  output logic [DATA_WD-1:0]     pl_rdata,
  output logic                   pl_stall_req,
  input  logic                   ax_req,
  input  logic [DATA_WD/8-1:0]   ax_we,
  input  logic [ADDR_WD-1:0]     ax_addr,
  input  logic [DATA_WD-1:0]     ax_wdata,
  output logic                   ax_gnt,
  output logic                   ax_rvalid,
  output logic [DATA_WD-1:0]     ax_rdata,
  output logic                   data_sram_en,
  output logic [DATA_WD/8-1:0]   data_sram_we,
  output logic [ADDR_WD-1:0]     data_sram_addr,
  output logic [DATA_WD-1:0]     data_sram_wdata,
  input  logic [DATA_WD-1:0]     data_sram_rdata
);

  localparam int BE_W = DATA_WD / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PL   = 2'd1,
    S_AX   = 2'd2
  } state_t;

  state_t state_p1;
  logic   pl_act_p0;
  logic   force_ax_p0;
  logic   gnt_ax_p0;
  logic   gnt_pl_p0;

  // Stage p0: grant decision and SRAM request mux (same cycle as the requests)
  assign pl_act_p0 = pl_en & ~flush;
  assign gnt_ax_p0 = ax_req & (~pl_act_p0 | force_ax_p0);
  assign gnt_pl_p0 = pl_act_p0 & ~gnt_ax_p0;

`ifdef DSRAM_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign force_ax_p0 = (starve_cnt == CNT_MAX);

  // Counts consecutive cycles the aux side waited; a grant or a dropped request restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (gnt_ax_p0 | ~ax_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_ax_p0 = 1'b0;
`endif

  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_we    = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (gnt_ax_p0) begin
      data_sram_en    = 1'b1;
      data_sram_we    = ax_we;
      data_sram_addr  = ax_addr;
      data_sram_wdata = ax_wdata;
    end else if (gnt_pl_p0) begin
      data_sram_en    = 1'b1;
      data_sram_we    = pl_we;
      data_sram_addr  = pl_addr;
      data_sram_wdata = pl_wdata;
    end
  end

  assign ax_gnt       = gnt_ax_p0;
  assign pl_stall_req = pl_act_p0 & gnt_ax_p0;

  // Stage p1: owner of the read issued last cycle; SRAM data returns now
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= S_IDLE;
    end else if (gnt_ax_p0 && (ax_we == '0)) begin
      state_p1 <= S_AX;
    end else if (gnt_pl_p0 && (pl_we == '0)) begin
      state_p1 <= S_PL;
    end else begin
      state_p1 <= S_IDLE;
    end
  end

  // Masking with reset drops a return that lands in the reset cycle itself.
  assign ax_rvalid = (state_p1 == S_AX) & ~reset;
  assign ax_rdata  = data_sram_rdata;
  assign pl_rdata  = data_sram_rdata;

  logic unused_be_w;
  assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_dsram_arbiter.sv
// Randomized + directed bench for dsram_arbiter against a cycle-level reference model.
module tb_dsram_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 4;
`ifdef DSRAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, flush, pl_en, ax_req;
  logic [BW-1:0] pl_we, ax_we;
  logic [AW-1:0] pl_addr, ax_addr;
  logic [DW-1:0] pl_wdata, ax_wdata;
  logic [DW-1:0] pl_rdata, ax_rdata;
  logic          pl_stall_req, ax_gnt, ax_rvalid;
  logic          data_sram_en;
  logic [BW-1:0] data_sram_we;
  logic [AW-1:0] data_sram_addr;
  logic [DW-1:0] data_sram_wdata, data_sram_rdata;

  always #5 clk = ~clk;

  dsram_arbiter #(.ADDR_WD(AW), .DATA_WD(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .pl_en(pl_en), .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata),
    .pl_rdata(pl_rdata), .pl_stall_req(pl_stall_req),
    .ax_req(ax_req), .ax_we(ax_we), .ax_addr(ax_addr), .ax_wdata(ax_wdata),
    .ax_gnt(ax_gnt), .ax_rvalid(ax_rvalid), .ax_rdata(ax_rdata),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata)
  );

  // SRAM environment driven by the DUT's port
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (data_sram_en) begin
      if (data_sram_we == '0) data_sram_rdata <= mem[data_sram_addr[9:2]];
      else
        for (int b = 0; b < BW; b++)
          if (data_sram_we[b]) mem[data_sram_addr[9:2]][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] refmem [0:255];
  bit            m_rv, m_plrd, m_last_gax;
  logic [DW-1:0] m_rdata;
  int            m_wait;
  int            n_chk = 0, n_fail = 0;
  int            ax_grants = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit            pl_act, frc, gax, gpl;
    logic [BW-1:0] ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    @(negedge clk);
    pl_act = pl_en && !flush;
    frc    = GUARD && (m_wait == LIM);
    gax    = ax_req && (!pl_act || frc);
    gpl    = pl_act && !gax;
    ewe = '0; ea = '0; ewd = '0;
    if (gax)      begin ewe = ax_we; ea = ax_addr; ewd = ax_wdata; end
    else if (gpl) begin ewe = pl_we; ea = pl_addr; ewd = pl_wdata; end
    check("ax_gnt", ax_gnt, gax);
    check("pl_stall_req", pl_stall_req, pl_act && gax);
    check("sram_en", data_sram_en, gax || gpl);
    check("sram_we", data_sram_we, ewe);
    check("sram_addr", data_sram_addr, ea);
    check("sram_wdata", data_sram_wdata, ewd);
    check("ax_rvalid", ax_rvalid, m_rv && !reset);
    if (m_rv && !reset) check("ax_rdata", ax_rdata, m_rdata);
    if (m_plrd && !reset) check("pl_rdata", pl_rdata, m_rdata);
    if (gax) ax_grants++;
    // SRAM contents follow whatever the model says was issued
    if (gax || gpl) begin
      if (ewe == '0) m_rdata = refmem[ea[9:2]];
      else
        for (int b = 0; b < BW; b++)
          if (ewe[b]) refmem[ea[9:2]][b*8 +: 8] = ewd[b*8 +: 8];
    end
    m_last_gax = gax;
    if (reset) begin
      m_rv = 0; m_plrd = 0; m_wait = 0;
    end else begin
      m_rv   = gax && (ax_we == '0);
      m_plrd = gpl && (pl_we == '0);
      if (gax || !ax_req) m_wait = 0;
      else if (m_wait < LIM) m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; pl_en = 0; pl_we = '0; pl_addr = '0; pl_wdata = '0;
    ax_req = 0; ax_we = '0; ax_addr = '0; ax_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      refmem[i] = mem[i];
    end
    data_sram_rdata = '0;
    m_rv = 0; m_plrd = 0; m_last_gax = 0; m_rdata = '0; m_wait = 0;
    idle_inputs();
    reset = 1;
    cycle(); cycle();
    reset = 0;
    cycle();

    // pipeline read at 0x100
    pl_en = 1; pl_addr = 32'h100;
    cycle();
    idle_inputs();
    cycle();

    // aux read at 0x200 with idle pipeline
    ax_req = 1; ax_addr = 32'h200;
    cycle();
    idle_inputs();
    cycle();

    // sustained contention, then pipeline releases
    ax_grants = 0;
    for (int i = 0; i < 10; i++) begin
      pl_en = 1; pl_addr = {22'd0, 8'($urandom), 2'b00};
      ax_req = 1; ax_addr = 32'h80;
      cycle();
    end
    check("contention_ax_grants", ax_grants, GUARD ? 2 : 0);
    pl_en = 0;
    cycle();
    idle_inputs();
    cycle();

    // flush drops the pipeline write; aux read issues instead
    flush = 1; pl_en = 1; pl_we = 4'hF; pl_addr = 32'h40; pl_wdata = 32'hDEADBEEF;
    ax_req = 1; ax_addr = 32'h40;
    cycle();
    idle_inputs();
    cycle();

    // reset right after an aux read grant drops the return
    ax_req = 1; ax_addr = 32'h44;
    cycle();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
    cycle();

    // randomized traffic; aux holds its fields until granted
    for (int n = 0; n < 600; n++) begin
      if (!ax_req || m_last_gax) begin
        ax_req   = ($urandom_range(0, 2) != 0);
        ax_we    = ($urandom_range(0, 1) != 0) ? BW'($urandom) : '0;
        ax_addr  = {22'd0, 8'($urandom), 2'b00};
        ax_wdata = $urandom;
      end
      pl_en    = $urandom_range(0, 1);
      flush    = ($urandom_range(0, 7) == 0);
      pl_we    = ($urandom_range(0, 1) != 0) ? BW'($urandom) : '0;
      pl_addr  = {22'd0, 8'($urandom), 2'b00};
      pl_wdata = $urandom;
      reset    = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 0;
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
